// File: rtl/draw_datapath.sv
// Draw-instruction executor: latches an instruction on a rising start edge, drives the VGA write port, reports a result word.
// Latency 2 edges (NOP/PLOT/error), 2+arg (DELAY), W*H+1 (CLEAR); start edges are ignored while busy, with no backpressure.
module draw_datapath #(
  parameter int SCREEN_WIDTH  = 160,
  parameter int SCREEN_HEIGHT = 120
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instruction,
  output logic        finished,
  output logic [31:0] result,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot
);

  localparam logic [7:0] LP_XMAX = 8'(SCREEN_WIDTH - 1);
  localparam logic [6:0] LP_YMAX = 7'(SCREEN_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_SWEEP,
    S_COUNT,
    S_DONE
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_start;
  logic [31:0] r_instr, w_instr_nxt;
  logic        r_err, w_err_nxt;
  logic [15:0] r_pix, w_pix_nxt;
  logic [8:0]  r_dly, w_dly_nxt;
  logic        r_fin, w_fin_nxt;
  logic [31:0] r_result, w_result_nxt;
  logic [7:0]  r_x, w_x_nxt;
  logic [6:0]  r_y, w_y_nxt;
  logic [2:0]  r_col, w_col_nxt;
  logic        r_plot, w_plot_nxt;

  logic [3:0]  w_op;
  logic [8:0]  w_arg;
  logic        w_plot_bit;
  logic [2:0]  w_fcol;
  logic [6:0]  w_fy;
  logic [7:0]  w_fx;
  logic        w_in_range;
  logic [7:0]  w_sweep_x;
  logic [6:0]  w_sweep_y;

  assign w_op       = r_instr[31:28];
  assign w_arg      = r_instr[27:19];
  assign w_plot_bit = r_instr[18];
  assign w_fcol     = r_instr[17:15];
  assign w_fy       = r_instr[14:8];
  assign w_fx       = r_instr[7:0];
  assign w_in_range = (w_fx <= LP_XMAX) && (w_fy <= LP_YMAX);

  // Raster step: x fastest, wrapping into the next row.
  assign w_sweep_x = (r_x == LP_XMAX) ? 8'd0 : r_x + 8'd1;
  assign w_sweep_y = (r_x == LP_XMAX) ? r_y + 7'd1 : r_y;

  always_comb begin
    w_state_nxt  = r_state;
    w_instr_nxt  = r_instr;
    w_err_nxt    = r_err;
    w_pix_nxt    = r_pix;
    w_dly_nxt    = r_dly;
    w_fin_nxt    = r_fin;
    w_result_nxt = r_result;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_col_nxt    = r_col;
    w_plot_nxt   = r_plot;
    case (r_state)
      S_IDLE: begin
        if (start && !r_start) begin
          w_instr_nxt = instruction;
          w_fin_nxt   = 1'b0;
          w_err_nxt   = 1'b0;
          w_pix_nxt   = 16'd0;
          w_dly_nxt   = 9'd0;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_nxt = S_DONE;
        case (w_op)
          4'd0: begin
          end
          4'd1: begin
            if (!w_in_range) begin
              w_err_nxt = 1'b1;
            end else if (w_plot_bit) begin
              w_x_nxt    = w_fx;
              w_y_nxt    = w_fy;
              w_col_nxt  = w_fcol;
              w_plot_nxt = 1'b1;
              w_pix_nxt  = 16'd1;
            end
          end
          4'd2: begin
            w_x_nxt     = 8'd0;
            w_y_nxt     = 7'd0;
            w_col_nxt   = w_fcol;
            w_plot_nxt  = 1'b1;
            w_pix_nxt   = 16'd1;
            w_state_nxt = S_SWEEP;
          end
          4'd3: begin
            if (w_arg != 9'd0) begin
              w_dly_nxt   = w_arg;
              w_state_nxt = S_COUNT;
            end
          end
          default: w_err_nxt = 1'b1;
        endcase
      end
      S_SWEEP: begin
        w_x_nxt   = w_sweep_x;
        w_y_nxt   = w_sweep_y;
        w_pix_nxt = r_pix + 16'd1;
        if (w_sweep_x == LP_XMAX && w_sweep_y == LP_YMAX) begin
          w_state_nxt = S_DONE;
        end
      end
      S_COUNT: begin
        w_dly_nxt = r_dly - 9'd1;
        if (r_dly == 9'd1) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_plot_nxt   = 1'b0;
        w_result_nxt = {w_op, r_err, 11'd0, r_pix};
        w_fin_nxt    = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_start  <= 1'b0;
      r_instr  <= 32'd0;
      r_err    <= 1'b0;
      r_pix    <= 16'd0;
      r_dly    <= 9'd0;
      r_fin    <= 1'b1;
      r_result <= 32'd0;
      r_x      <= 8'd0;
      r_y      <= 7'd0;
      r_col    <= 3'd0;
      r_plot   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_start  <= start;
      r_instr  <= w_instr_nxt;
      r_err    <= w_err_nxt;
      r_pix    <= w_pix_nxt;
      r_dly    <= w_dly_nxt;
      r_fin    <= w_fin_nxt;
      r_result <= w_result_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_col    <= w_col_nxt;
      r_plot   <= w_plot_nxt;
    end
  end

  assign finished   = r_fin;
  assign result     = r_result;
  assign vga_x      = r_x;
  assign vga_y      = r_y;
  assign vga_colour = r_col;
  assign vga_plot   = r_plot;

endmodule

// File: tb/tb_draw_datapath.sv
// Bench for draw_datapath: directed handshake/boundary steps plus randomized instructions scored against a behavioural model.
module tb_draw_datapath;
  localparam int W = 160;
  localparam int H = 120;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] instruction;
  logic        finished;
  logic [31:0] result;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res;
  logic [17:0] wq[$];

  draw_datapath #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
    .clock(clock), .reset(reset), .start(start), .instruction(instruction),
    .finished(finished), .result(result), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every cycle with vga_plot high is one pixel written by the adapter.
  always @(negedge clock) begin
    if (vga_plot === 1'b1) wq.push_back({vga_x, vga_y, vga_colour});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int arg, input int pl, input int col,
                                     input int y, input int x);
    logic [31:0] w;
    w = {op[3:0], arg[8:0], pl[0], col[2:0], y[6:0], x[7:0]};
    return w;
  endfunction

  // Behavioural model: result word, edges until finished, pixels written.
  task automatic model(input logic [31:0] ins, output logic [31:0] res, output int lat, output int nwr);
    int op, x, y, cnt;
    bit err;
    op = int'(ins[31:28]); x = int'(ins[7:0]); y = int'(ins[14:8]);
    err = 0; cnt = 0; lat = 2;
    if (op == 1) begin
      if (x >= W || y >= H) err = 1;
      else if (ins[18]) cnt = 1;
    end else if (op == 2) begin
      cnt = W * H; lat = W * H + 1;
    end else if (op == 3) begin
      lat = 2 + int'(ins[27:19]);
    end else if (op != 0) begin
      err = 1;
    end
    nwr = cnt;
    res = {ins[31:28], err, 11'd0, cnt[15:0]};
  endtask

  task automatic op(input string tag, input logic [31:0] ins, input int hold, input int pulse);
    logic [31:0] eres;
    int elat, enwr, lat, first, extra, k, bad;
    model(ins, eres, elat, enwr);
    lat = -1; first = -1; extra = 0; k = 0;
    @(negedge clock);
    instruction = ins; start = 1'b1; wq.delete();
    @(posedge clock);
    @(negedge clock);
    check({tag, "_fin_low_at_A"}, finished, 1'b0);
    check({tag, "_result_held"}, result, last_res);
    if (vga_plot) first = 0;
    if (hold <= 1) start = 1'b0;
    while ((lat < 0 || k + 1 < hold) && k < 25000) begin
      @(posedge clock);
      @(negedge clock);
      k++;
      if (k + 1 >= hold) start = 1'b0;
      if (pulse > 0 && k == pulse) start = 1'b1;
      if (vga_plot && first < 0) first = k;
      if (lat < 0 && finished) lat = k;
      else if (lat >= 0 && !finished) extra++;
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, elat);
    check({tag, "_result"}, result, eres);
    check({tag, "_writes"}, wq.size(), enwr);
    check({tag, "_first_write_edge"}, first, (enwr > 0) ? 1 : -1);
    check({tag, "_no_reaccept"}, extra, 0);
    if (ins[31:28] == 4'd1 && enwr == 1 && wq.size() > 0)
      check({tag, "_pixel"}, 32'(wq[0]), 32'({ins[7:0], ins[14:8], ins[17:15]}));
    if (ins[31:28] == 4'd2) begin
      bad = 0;
      for (int i = 0; i < wq.size(); i++) begin
        if (wq[i] !== {8'(i % W), 7'(i / W), ins[17:15]}) bad++;
      end
      check({tag, "_raster_order"}, bad, 0);
    end
    last_res = eres;
  endtask

  initial begin
    logic [31:0] ins;
    int rop, x, y;
    reset = 1'b1; start = 1'b0; instruction = 32'd0; last_res = 32'd0;
    repeat (3) @(negedge clock);
    check("rst_finished", finished, 1'b1);
    check("rst_result", result, 32'd0);
    check("rst_plot", vga_plot, 1'b0);
    check("rst_xyc", {vga_x, vga_y, vga_colour}, 0);
    reset = 1'b0;

    op("plot", mk(1, 0, 1, 5, 10, 20), 2, 0);
    check("plot_word", result, 32'h1000_0001);
    op("plot_xoob", mk(1, 0, 1, 5, 10, 160), 1, 0);
    check("plot_xoob_word", result, 32'h1800_0000);
    op("plot_off", mk(1, 0, 0, 5, 10, 20), 1, 0);
    check("plot_off_word", result, 32'h1000_0000);
    op("plot_corner", mk(1, 0, 1, 7, 119, 159), 1, 0);
    op("plot_yoob", mk(1, 0, 1, 7, 120, 0), 1, 0);

    // Reset in the middle of a CLEAR sweep.
    @(negedge clock);
    instruction = mk(2, 0, 0, 6, 0, 0); start = 1'b1; wq.delete();
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 2000 && wq.size() < 500; i++) @(negedge clock);
    check("clear_reached_500", wq.size() >= 500, 1'b1);
    reset = 1'b1;
    #1;
    check("midrst_plot", vga_plot, 1'b0);
    check("midrst_finished", finished, 1'b1);
    check("midrst_result", result, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    last_res = 32'd0;
    op("nop_after_rst", mk(0, 0, 0, 0, 0, 0), 1, 0);

    op("clear", mk(2, 0, 0, 2, 55, 99), 1, 1000);
    check("clear_count", result[15:0], 16'd19200);
    op("delay5", mk(3, 5, 0, 0, 0, 0), 1, 0);
    op("delay0", mk(3, 0, 0, 0, 0, 0), 1, 0);
    op("nop_held", mk(0, 0, 0, 0, 0, 0), 10, 0);
    op("bad_op9", mk(9, 0, 1, 1, 1, 1), 1, 0);
    check("bad_op9_err", result[27], 1'b1);

    for (int n = 0; n < 40; n++) begin
      rop = $urandom_range(0, 15);
      if (rop == 2) rop = 1;
      ins = $urandom;
      ins[31:28] = 4'(rop);
      if (rop == 3) ins[27:19] = 9'($urandom_range(0, 12));
      if (rop == 1) begin
        x = $urandom_range(0, 175);
        y = $urandom_range(0, 127);
        ins[7:0] = 8'(x);
        ins[14:8] = 7'(y);
        if (x >= W || y >= H) ins[18] = 1'b1;
      end
      op("rand", ins, $urandom_range(1, 4), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
